// File: rtl/de0_nano_sysid_checker.sv
// Reads the sysid slave (word 0 = ID, word 1 = timestamp), compares against build-time values, retries on mismatch.
// Optional: define SYSID_CHECK_AUTOSTART_EN to launch one check automatically after every reset release.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start, address 0, results held
// S_RD_ID | address 0 held for READ_LATENCY cycles, then ID captured
// S_RD_TS | address 1 held for READ_LATENCY cycles, then timestamp captured
// S_CMP   | flags registered, retry or finish
// S_DONE  | one-cycle done pulse
module de0_nano_sysid_checker #(
  parameter logic [31:0] EXPECTED_ID        = 32'd0,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1380075566,
  parameter int          READ_LATENCY       = 1,
  parameter int          RETRY_MAX          = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        sysid_address,
  input  logic [31:0] sysid_readdata,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        id_ok,
  output logic        ts_ok,
  output logic [31:0] captured_id,
  output logic [31:0] captured_ts,
  output logic [3:0]  retry_count
);

  localparam int LAT_CLAMP = (READ_LATENCY < 1) ? 1 : ((READ_LATENCY > 15) ? 15 : READ_LATENCY);
  localparam logic [3:0] LAT_LOAD  = 4'(LAT_CLAMP - 1);
  localparam logic [3:0] RETRY_LIM = (RETRY_MAX < 0) ? 4'd0 : ((RETRY_MAX > 15) ? 4'd15 : 4'(RETRY_MAX));

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD_ID = 3'd1,
    S_RD_TS = 3'd2,
    S_CMP   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t     state_q;
  state_t     state_nxt;
  logic [3:0] lat_cnt;
  logic       start_eff;
  logic       lat_zero;
  logic       id_match;
  logic       ts_match;
  logic       retry_ok;
  logic       do_retry;

`ifdef SYSID_CHECK_AUTOSTART_EN
  // Set while reset is held, so exactly the first post-reset IDLE cycle sees a start.
  logic autostart_q;

  always_ff @(posedge clock) begin
    if (reset) autostart_q <= 1'b1;
    else       autostart_q <= 1'b0;
  end

  assign start_eff = start | autostart_q;
`else
  assign start_eff = start;
`endif

  assign lat_zero = (lat_cnt == 4'd0);
  assign id_match = (captured_id == EXPECTED_ID);
  assign ts_match = (captured_ts == EXPECTED_TIMESTAMP);
  assign retry_ok = (retry_count < RETRY_LIM);
  assign do_retry = !(id_match && ts_match) && retry_ok;

  always_ff @(posedge clock) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      S_IDLE:  if (start_eff) state_nxt = S_RD_ID;
      S_RD_ID: if (lat_zero)  state_nxt = S_RD_TS;
      S_RD_TS: if (lat_zero)  state_nxt = S_CMP;
      S_CMP:   state_nxt = do_retry ? S_RD_ID : S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    sysid_address = 1'b0;
    busy          = 1'b1;
    done          = 1'b0;
    case (state_q)
      S_IDLE:  busy = 1'b0;
      S_RD_TS: sysid_address = 1'b1;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Capture, latency counting and result flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      lat_cnt     <= 4'd0;
      captured_id <= 32'd0;
      captured_ts <= 32'd0;
      id_ok       <= 1'b0;
      ts_ok       <= 1'b0;
      pass        <= 1'b0;
      retry_count <= 4'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_eff) begin
            retry_count <= 4'd0;
            id_ok       <= 1'b0;
            ts_ok       <= 1'b0;
            pass        <= 1'b0;
            lat_cnt     <= LAT_LOAD;
          end
        end
        S_RD_ID: begin
          if (!lat_zero) begin
            lat_cnt <= lat_cnt - 4'd1;
          end else begin
            captured_id <= sysid_readdata;
            lat_cnt     <= LAT_LOAD;
          end
        end
        S_RD_TS: begin
          if (!lat_zero) lat_cnt <= lat_cnt - 4'd1;
          else           captured_ts <= sysid_readdata;
        end
        S_CMP: begin
          id_ok <= id_match;
          ts_ok <= ts_match;
          pass  <= id_match && ts_match;
          if (do_retry) begin
            retry_count <= retry_count + 4'd1;
            lat_cnt     <= LAT_LOAD;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_de0_nano_sysid_checker.sv
// Bench for de0_nano_sysid_checker: two instances (latency 1 / 3 retries, latency 3 / no retries),
// a per-pass programmable sysid slave and a pass-count reference model.
module tb_de0_nano_sysid_checker;

  localparam logic [31:0] EXP_ID = 32'd0;
  localparam logic [31:0] EXP_TS = 32'd1380075566;

  logic        clock;
  logic        reset;
  logic        start    [2];
  logic        addr     [2];
  logic [31:0] rdata    [2];
  logic        busy     [2];
  logic        done     [2];
  logic        pass_o   [2];
  logic        id_ok    [2];
  logic        ts_ok    [2];
  logic [31:0] cap_id   [2];
  logic [31:0] cap_ts   [2];
  logic [3:0]  rcnt     [2];

  logic [31:0] id_tab [2][8];
  logic [31:0] ts_tab [2][8];
  int          fall_cnt  [2] = '{0, 0};
  logic        prev_addr [2] = '{1'b0, 1'b0};
  int          base      [2] = '{0, 0};

  int tests = 0;
  int fails = 0;

  int          first_done, last_done, n_done;
  logic [63:0] abits, bbits;
  logic        s_pass, s_id_ok, s_ts_ok;
  logic [3:0]  s_rcnt;
  logic [31:0] s_cid, s_cts;

  de0_nano_sysid_checker #(
    .EXPECTED_ID(EXP_ID), .EXPECTED_TIMESTAMP(EXP_TS), .READ_LATENCY(1), .RETRY_MAX(3)
  ) u_dut0 (
    .clock(clock), .reset(reset), .start(start[0]), .sysid_address(addr[0]),
    .sysid_readdata(rdata[0]), .busy(busy[0]), .done(done[0]), .pass(pass_o[0]),
    .id_ok(id_ok[0]), .ts_ok(ts_ok[0]), .captured_id(cap_id[0]), .captured_ts(cap_ts[0]),
    .retry_count(rcnt[0])
  );

  de0_nano_sysid_checker #(
    .EXPECTED_ID(EXP_ID), .EXPECTED_TIMESTAMP(EXP_TS), .READ_LATENCY(3), .RETRY_MAX(0)
  ) u_dut1 (
    .clock(clock), .reset(reset), .start(start[1]), .sysid_address(addr[1]),
    .sysid_readdata(rdata[1]), .busy(busy[1]), .done(done[1]), .pass(pass_o[1]),
    .id_ok(id_ok[1]), .ts_ok(ts_ok[1]), .captured_id(cap_id[1]), .captured_ts(cap_ts[1]),
    .retry_count(rcnt[1])
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // A read pass ends when the address drops from 1 back to 0.
  always @(negedge clock) begin
    for (int u = 0; u < 2; u++) begin
      if (prev_addr[u] === 1'b1 && addr[u] === 1'b0) fall_cnt[u] <= fall_cnt[u] + 1;
      prev_addr[u] <= addr[u];
    end
  end

  // Slave: combinational, contents selected by the read pass in progress.
  always_comb begin
    int p;
    for (int u = 0; u < 2; u++) begin
      p = fall_cnt[u] - base[u];
      if (p < 0) p = 0;
      if (p > 7) p = 7;
      rdata[u] = (addr[u] === 1'b1) ? ts_tab[u][p] : id_tab[u][p];
    end
  end

  function automatic int lat_of(input int u);
    return (u == 0) ? 1 : 3;
  endfunction

  function automatic int rmax_of(input int u);
    return (u == 0) ? 3 : 0;
  endfunction

  task automatic fill_good(input int u);
    for (int k = 0; k < 8; k++) begin
      id_tab[u][k] = EXP_ID;
      ts_tab[u][k] = EXP_TS;
    end
  endtask

  task automatic release_reset();
    reset = 1'b0;
`ifdef SYSID_CHECK_AUTOSTART_EN
    repeat (20) @(negedge clock);
`else
    repeat (2) @(negedge clock);
`endif
  endtask

  // Start in cycle 0, observe cycles 1..window, then wait (bounded) for idle.
  task automatic run(input int u, input bit hold, input int p1, input int p2, input int window);
    @(negedge clock);
    base[u]  = fall_cnt[u];
    start[u] = 1'b1;
    first_done = 0; last_done = 0; n_done = 0; abits = '0; bbits = '0;
    for (int c = 1; c <= window; c++) begin
      @(negedge clock);
      if (!hold) start[u] = (c == p1) || (c == p2);
      if (c < 64) begin
        abits[c] = addr[u];
        bbits[c] = busy[u];
      end
      if (done[u] === 1'b1) begin
        n_done++;
        last_done = c;
        if (first_done == 0) begin
          first_done = c;
          s_pass = pass_o[u]; s_id_ok = id_ok[u]; s_ts_ok = ts_ok[u];
          s_rcnt = rcnt[u]; s_cid = cap_id[u]; s_cts = cap_ts[u];
        end
      end
    end
    start[u] = 1'b0;
    for (int k = 0; k < 100 && busy[u] !== 1'b0; k++) @(negedge clock);
    tests++;
    if (busy[u] !== 1'b0) begin
      fails++; $display("FAIL drain_idle u%0d: busy=%b required 0", u, busy[u]);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int u = 0; u < 2; u++) begin start[u] = 1'b0; fill_good(u); end
    repeat (3) @(negedge clock);
    for (int u = 0; u < 2; u++) begin
      tests++;
      if ({busy[u], done[u], addr[u], pass_o[u], id_ok[u], ts_ok[u], rcnt[u], cap_id[u], cap_ts[u]} !== '0) begin
        fails++;
        $display("FAIL reset_outputs u%0d: busy=%b done=%b addr=%b pass=%b rc=%0d cid=%h cts=%h required all 0",
                 u, busy[u], done[u], addr[u], pass_o[u], rcnt[u], cap_id[u], cap_ts[u]);
      end
    end
    release_reset();
  endtask

  task automatic test_basic();
    fill_good(0);
    run(0, 1'b0, 0, 0, 8);
    tests++; if (first_done !== 4) begin fails++; $display("FAIL basic_done_cycle: got %0d required 4", first_done); end
    tests++; if (n_done !== 1) begin fails++; $display("FAIL basic_done_count: got %0d required 1", n_done); end
    tests++;
    if ({s_pass, s_id_ok, s_ts_ok, s_rcnt} !== {3'b111, 4'd0}) begin
      fails++; $display("FAIL basic_flags: pass=%b id=%b ts=%b rc=%0d required 1 1 1 0", s_pass, s_id_ok, s_ts_ok, s_rcnt);
    end
    tests++; if (abits[4:1] !== 4'b0010) begin fails++; $display("FAIL basic_addr_seq: got %b required 0010", abits[4:1]); end
    tests++; if (bbits[5:1] !== 5'b01111) begin fails++; $display("FAIL basic_busy_seq: got %b required 01111", bbits[5:1]); end
    tests++; if (pass_o[0] !== 1'b1) begin fails++; $display("FAIL basic_pass_hold: got %b required 1", pass_o[0]); end
  endtask

  task automatic test_retry_exhaust();
    fill_good(0);
    for (int k = 0; k < 8; k++) id_tab[0][k] = 32'd1;
    run(0, 1'b0, 0, 0, 18);
    tests++; if (first_done !== 13) begin fails++; $display("FAIL exhaust_done_cycle: got %0d required 13", first_done); end
    tests++;
    if ({s_pass, s_id_ok, s_ts_ok, s_rcnt, s_cid} !== {3'b001, 4'd3, 32'd1}) begin
      fails++; $display("FAIL exhaust_flags: pass=%b id=%b ts=%b rc=%0d cid=%h required 0 0 1 3 1",
                        s_pass, s_id_ok, s_ts_ok, s_rcnt, s_cid);
    end
  endtask

  task automatic test_retry_once();
    fill_good(0);
    ts_tab[0][0] = EXP_TS ^ 32'h0000_0100;
    run(0, 1'b0, 0, 0, 12);
    tests++; if (first_done !== 7) begin fails++; $display("FAIL once_done_cycle: got %0d required 7", first_done); end
    tests++;
    if ({s_pass, s_rcnt} !== {1'b1, 4'd1}) begin
      fails++; $display("FAIL once_flags: pass=%b rc=%0d required 1 1", s_pass, s_rcnt);
    end
  endtask

  task automatic test_latency3();
    fill_good(1);
    run(1, 1'b0, 2, 5, 16);
    tests++; if (first_done !== 8) begin fails++; $display("FAIL lat3_done_cycle: got %0d required 8", first_done); end
    tests++; if (n_done !== 1) begin fails++; $display("FAIL lat3_done_count: got %0d required 1", n_done); end
    tests++; if (abits[8:1] !== 8'b00111000) begin fails++; $display("FAIL lat3_addr_seq: got %b required 00111000", abits[8:1]); end
    tests++; if (s_pass !== 1'b1) begin fails++; $display("FAIL lat3_pass: got %b required 1", s_pass); end
  endtask

  task automatic test_rmax0();
    fill_good(1);
    for (int k = 0; k < 8; k++) id_tab[1][k] = 32'hDEAD_BEEF;
    run(1, 1'b0, 0, 0, 14);
    tests++; if (first_done !== 8) begin fails++; $display("FAIL rmax0_done_cycle: got %0d required 8", first_done); end
    tests++;
    if ({s_pass, s_id_ok, s_ts_ok, s_rcnt, s_cid} !== {3'b001, 4'd0, 32'hDEAD_BEEF}) begin
      fails++; $display("FAIL rmax0_flags: pass=%b id=%b ts=%b rc=%0d cid=%h required 0 0 1 0 deadbeef",
                        s_pass, s_id_ok, s_ts_ok, s_rcnt, s_cid);
    end
  endtask

  task automatic test_start_in_done();
    fill_good(0);
    run(0, 1'b0, 4, 0, 12);
    tests++; if (n_done !== 1) begin fails++; $display("FAIL done_start_count: got %0d required 1", n_done); end
    tests++; if (bbits[12:5] !== 8'd0) begin fails++; $display("FAIL done_start_busy: got %b required 00000000", bbits[12:5]); end
  endtask

  task automatic test_back_to_back();
    fill_good(0);
    run(0, 1'b1, 0, 0, 12);
    tests++; if (n_done !== 2) begin fails++; $display("FAIL b2b_done_count: got %0d required 2", n_done); end
    tests++; if (first_done !== 4) begin fails++; $display("FAIL b2b_first_done: got %0d required 4", first_done); end
    tests++; if (last_done !== 9) begin fails++; $display("FAIL b2b_second_done: got %0d required 9", last_done); end
  endtask

  task automatic test_reset_mid();
    fill_good(0);
    ts_tab[0][0] = 32'h1234_5678;
    @(negedge clock);
    base[0] = fall_cnt[0]; start[0] = 1'b1;
    @(negedge clock);
    start[0] = 1'b0;
    repeat (4) @(negedge clock);
    tests++;
    if ({addr[0], rcnt[0]} !== {1'b1, 4'd1}) begin
      fails++; $display("FAIL midrst_pre: addr=%b rc=%0d required 1 1", addr[0], rcnt[0]);
    end
    reset = 1'b1;
    @(negedge clock);
    tests++;
    if ({busy[0], done[0], pass_o[0], id_ok[0], ts_ok[0], rcnt[0], cap_id[0], cap_ts[0]} !== '0) begin
      fails++; $display("FAIL midrst_clear: busy=%b done=%b pass=%b rc=%0d cts=%h required all 0",
                        busy[0], done[0], pass_o[0], rcnt[0], cap_ts[0]);
    end
    release_reset();
    fill_good(0);
    run(0, 1'b0, 0, 0, 8);
    tests++;
    if ({first_done == 4, s_pass, s_rcnt, s_cts} !== {2'b11, 4'd0, EXP_TS}) begin
      fails++; $display("FAIL midrst_recheck: done_cycle=%0d pass=%b rc=%0d cts=%h required 4 1 0 %h",
                        first_done, s_pass, s_rcnt, s_cts, EXP_TS);
    end
  endtask

  task automatic test_autostart();
    int n [2];
    logic p [2];
    int exp_n;
`ifdef SYSID_CHECK_AUTOSTART_EN
    exp_n = 1;
`else
    exp_n = 0;
`endif
    for (int u = 0; u < 2; u++) begin fill_good(u); n[u] = 0; p[u] = 1'b0; start[u] = 1'b0; end
    reset = 1'b1;
    repeat (2) @(negedge clock);
    base[0] = fall_cnt[0]; base[1] = fall_cnt[1];
    reset = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clock);
      for (int u = 0; u < 2; u++) if (done[u] === 1'b1) begin n[u]++; p[u] = pass_o[u]; end
    end
    for (int u = 0; u < 2; u++) begin
      tests++;
      if (n[u] !== exp_n || (n[u] == 1 && p[u] !== 1'b1)) begin
        fails++; $display("FAIL autostart u%0d: dones=%0d pass=%b required %0d dones with pass 1", u, n[u], p[u], exp_n);
      end
    end
  endtask

  task automatic test_random();
    int u, lat, rmax, passes, last, exp_done;
    for (int it = 0; it < 16; it++) begin
      u = (it < 12) ? 0 : 1;
      lat = lat_of(u);
      rmax = rmax_of(u);
      for (int k = 0; k < 8; k++) begin
        id_tab[u][k] = ($urandom_range(0, 1) == 1) ? EXP_ID : $urandom;
        ts_tab[u][k] = ($urandom_range(0, 2) != 0) ? EXP_TS : $urandom;
      end
      // A check stops at the first fully matching pass, or after RETRY_MAX extra passes.
      passes = 0;
      for (int k = 0; k <= rmax; k++) begin
        passes = k + 1;
        if (id_tab[u][k] == EXP_ID && ts_tab[u][k] == EXP_TS) break;
      end
      last = passes - 1;
      exp_done = passes * (2 * lat + 1) + 1;
      run(u, 1'b0, 0, 0, (rmax + 1) * (2 * lat + 1) + 5);
      tests++;
      if (first_done !== exp_done || n_done !== 1) begin
        fails++; $display("FAIL rand_timing it%0d: done_cycle=%0d count=%0d required %0d 1", it, first_done, n_done, exp_done);
      end
      tests++;
      if (s_rcnt !== 4'(last) || s_cid !== id_tab[u][last] || s_cts !== ts_tab[u][last]) begin
        fails++; $display("FAIL rand_capture it%0d: rc=%0d cid=%h cts=%h required %0d %h %h",
                          it, s_rcnt, s_cid, s_cts, last, id_tab[u][last], ts_tab[u][last]);
      end
      tests++;
      if (s_id_ok !== (id_tab[u][last] == EXP_ID) || s_ts_ok !== (ts_tab[u][last] == EXP_TS) ||
          s_pass !== (id_tab[u][last] == EXP_ID && ts_tab[u][last] == EXP_TS)) begin
        fails++; $display("FAIL rand_flags it%0d: id=%b ts=%b pass=%b", it, s_id_ok, s_ts_ok, s_pass);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    start[0] = 1'b0;
    start[1] = 1'b0;
    test_reset();
    test_basic();
    test_retry_exhaust();
    test_retry_once();
    test_latency3();
    test_rmax0();
    test_start_in_done();
    test_back_to_back();
    test_reset_mid();
    test_autostart();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
